// File: rtl/psum_gather16.sv
// psum_gather16: producer side of the 16-lane signed partial-sum adder tree.
// Packs one signed partial sum per accepted beat into a 16-lane vector. The
// vector is held stable on tree_in for TREE_LATENCY cycles. The tree result is
// then captured and offered on a valid/ready output.
//
// Optional build macro: PSUM_GATHER_ACCUM_EN
//   When it is defined, a wrapping accumulator sums the tree results of full
//   16-beat groups. Only a group that ends with in_last produces an output,
//   and that output is the running total. When it is undefined, every group
//   produces one output.
module psum_gather16 #(
    parameter int WIDTH_IN     = 8,
    parameter int TREE_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH_IN+10:0] in_data,
    input  logic                       in_last,
    output logic signed [WIDTH_IN+10:0] tree_in [15:0],
    input  logic signed [WIDTH_IN+10:0] tree_out,
    output logic                       out_valid,
    output logic signed [WIDTH_IN+10:0] out_data,
    input  logic                       out_ready
);

    localparam int W = WIDTH_IN + 11;
    localparam logic [3:0] LAT_LAST = 4'(TREE_LATENCY);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t     state;
    logic [3:0] count;
    logic [3:0] lat_cnt;
    logic       accept;

`ifdef PSUM_GATHER_ACCUM_EN
    logic signed [W-1:0] acc;
    logic                grp_last;
`endif

    // NOTE: in_ready is decoded from the state and gated with rst_n. This
    // keeps the upstream stage from seeing a ready while reset is held.
    assign in_ready = rst_n && (state == ST_FILL);
    assign accept   = in_valid && in_ready;

    // Group sequencing: fill lanes, hold for the tree, capture, hand off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            count     <= '0;
            lat_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            // NOTE: the lane registers drive the adder tree directly, so they
            // are reset like any other state rather than treated as memory.
            for (int i = 0; i < 16; i++) begin
                tree_in[i] <= '0;
            end
`ifdef PSUM_GATHER_ACCUM_EN
            acc      <= '0;
            grp_last <= 1'b0;
`endif
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        // Write this beat into its lane. A closing in_last
                        // zero-fills the lanes above it.
                        for (int i = 0; i < 16; i++) begin
                            if (4'(i) == count) begin
                                tree_in[i] <= in_data;
                            end else if (in_last && (4'(i) > count)) begin
                                tree_in[i] <= '0;
                            end
                        end
                        count <= count + 4'd1;
                        if (in_last || (count == 4'd15)) begin
                            state   <= ST_WAIT;
                            lat_cnt <= '0;
`ifdef PSUM_GATHER_ACCUM_EN
                            grp_last <= in_last;
`endif
                        end
                    end
                end

                ST_WAIT: begin
                    lat_cnt <= lat_cnt + 4'd1;
                    if ((lat_cnt + 4'd1) == LAT_LAST) begin
                        lat_cnt <= '0;
`ifdef PSUM_GATHER_ACCUM_EN
                        if (grp_last) begin
                            out_data  <= acc + tree_out;
                            acc       <= '0;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            // Full group without in_last: fold it into the
                            // running total and start the next group.
                            acc   <= acc + tree_out;
                            count <= '0;
                            for (int i = 0; i < 16; i++) begin
                                tree_in[i] <= '0;
                            end
                            state <= ST_FILL;
                        end
`else
                        out_data  <= tree_out;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
`endif
                    end
                end

                ST_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        count     <= '0;
                        for (int i = 0; i < 16; i++) begin
                            tree_in[i] <= '0;
                        end
                        state <= ST_FILL;
                    end
                end

                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule
